kernel_launch_ctrl: RTL

//  Host-side sequencer for one synthesized kernel (main + arr_a). Accepts a command, streams the

---
 rtl/klc_pkg.sv | 19 +
 rtl/klc_watchdog.sv | 32 +++
 rtl/kernel_launch_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/klc_pkg.sv
// Shared types and default widths for the kernel launch controller.
// Optional watchdog is enabled by defining KLC_WATCHDOG_EN.
package klc_pkg;

    localparam int KLC_ADDR_W = 10;
    localparam int KLC_DATA_W = 27;
    localparam int KLC_DEPTH  = 1000;
    localparam int KLC_RES_W  = 64;
    localparam int KLC_WDOG_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        RUN,
        RESP
    } klc_state_e;

endpackage

// File: rtl/klc_watchdog.sv
// Saturating RUN-cycle counter for the kernel launch controller.
// Only instantiated when KLC_WATCHDOG_EN is defined.
module klc_watchdog
    import klc_pkg::*;
#(
    parameter int WDOG_W = KLC_WDOG_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the RUN cycle whose closing edge brings the count to all-ones.
    assign expire = run && (cnt >= LAST);

endmodule

// File: rtl/kernel_launch_ctrl.sv
// Host-side sequencer: load arr_a, pulse r_enable, wait for w_enable, return result.
// Define KLC_WATCHDOG_EN to abort RUN after 2**WDOG_W-1 cycles with res_err=1.
module kernel_launch_ctrl
    import klc_pkg::*;
#(
    parameter int ADDR_W = KLC_ADDR_W,
    parameter int DATA_W = KLC_DATA_W,
    parameter int DEPTH  = KLC_DEPTH,
    parameter int RES_W  = KLC_RES_W
`ifdef KLC_WATCHDOG_EN
    ,parameter int WDOG_W = KLC_WDOG_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [ADDR_W-1:0] cmd_init_i,
    input  logic [RES_W-1:0]  cmd_init_acc,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_err,
    output logic              busy,
    output logic              k_r_enable,
    output logic [ADDR_W-1:0] k_init_i,
    output logic [RES_W-1:0]  k_init_acc,
    output logic              k_ctrl_arr,
    output logic              k_arr_we,
    output logic [ADDR_W-1:0] k_arr_addr,
    output logic [DATA_W-1:0] k_arr_wdata,
    input  logic              k_w_enable,
    input  logic [RES_W-1:0]  k_result
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    klc_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_last;
    logic              wd_expire;

`ifdef KLC_WATCHDOG_EN
    klc_watchdog #(
        .WDOG_W (WDOG_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == LAUNCH),
        .run    (state == RUN),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // NOTE: the array write strobe follows ld_valid combinationally so a word is
    // written on the same edge as its handshake; ld_ready gates it outside LOAD.
    assign k_arr_we    = ld_ready & ld_valid;
    assign k_arr_addr  = addr_q;
    assign k_arr_wdata = ld_ready ? ld_data : '0;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_last   <= '0;
            cmd_ready  <= 1'b0;
            ld_ready   <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
            busy       <= 1'b0;
            k_r_enable <= 1'b0;
            k_init_i   <= '0;
            k_init_acc <= '0;
            k_ctrl_arr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!cmd_ready) begin
                        cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        k_init_i   <= cmd_init_i;
                        k_init_acc <= cmd_init_acc;
                        len_last   <= ADDR_W'(cmd_len - 1'b1);
                        addr_q     <= '0;
                        if (cmd_len > DEPTH_L) begin
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_data  <= '0;
                            state     <= RESP;
                        end else if (cmd_len == '0) begin
                            k_r_enable <= 1'b1;
                            state      <= LAUNCH;
                        end else begin
                            ld_ready   <= 1'b1;
                            k_ctrl_arr <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (ld_valid) begin
                        if (addr_q == len_last) begin
                            addr_q     <= '0;
                            ld_ready   <= 1'b0;
                            k_ctrl_arr <= 1'b0;
                            k_r_enable <= 1'b1;
                            state      <= LAUNCH;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end

                // w_enable may still be high from the previous run; it is not sampled here.
                LAUNCH: begin
                    k_r_enable <= 1'b0;
                    state      <= RUN;
                end

                RUN: begin
                    if (k_w_enable) begin
                        res_data  <= k_result;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wd_expire) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
